// File: rtl/hub75_scan_driver_if.sv
// Frame RAM read port: address/strobe out of the scan engine, pixel word back
// one cycle after the strobe.
interface hub75_scan_driver_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 54
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_addr, output rd_en, input rd_data);
  modport slave  (input rd_addr, input rd_en, output rd_data);
endinterface

// File: rtl/hub75_scan_driver.sv
// HUB75 scan engine: fetches pixel words from a dual-buffer frame RAM, shifts
// 2*CHAINS RGB lanes per column with thresholded PWM, sequences blank/latch/
// row-select, swaps display buffers at frame end and stops cleanly at row
// boundaries when disabled.
module hub75_scan_driver #(
  parameter int COLS     = 160,
  parameter int ROWS     = 20,
  parameter int CHAINS   = 3,
  parameter int PWM_BITS = 3,
  parameter int ROW_W    = 5,
  parameter int ADDR_W   = 13
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_swap_req,
  hub75_scan_driver_if.master   ram,
  output logic                  o_data_clock,
  output logic                  o_data_latch,
  output logic                  o_data_blank,
  output logic [2*CHAINS-1:0]   o_data_r,
  output logic [2*CHAINS-1:0]   o_data_g,
  output logic [2*CHAINS-1:0]   o_data_b,
  output logic [ROW_W-1:0]      o_row_select,
  output logic                  o_buf_sel,
  output logic                  o_swap_ack,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PIX_W = 3 * PWM_BITS;
  localparam int LANES = 2 * CHAINS;

  localparam logic [COL_W-1:0]    COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]    ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_DATA, S_CLK, S_BLANK, S_LATCH, S_ROW, S_UNLATCH, S_UNBLANK
  } state_t;

  state_t              state, state_n;
  logic [COL_W-1:0]    col, col_n;
  logic [ROW_W-1:0]    row, row_n;
  logic [PWM_BITS-1:0] pwm, pwm_n;
  logic                buf_sel, buf_n;
  logic                swap_pend, pend_n;
  logic [LANES-1:0]    r_q, g_q, b_q, r_n, g_n, b_n;
  logic [LANES-1:0]    lane_r, lane_g, lane_b;
  logic [PIX_W-1:0]    pix;
  logic                frame_end;

  // Control strobes are pure state decodes; latch spans LATCH..ROW so it is
  // high for exactly two cycles, and the panel stays dark from BLANK until UNBLANK.
  assign o_data_clock = (state == S_CLK);
  assign o_data_latch = (state == S_LATCH) || (state == S_ROW);
  assign o_data_blank = (state == S_IDLE) || (state == S_BLANK) || (state == S_LATCH) ||
                        (state == S_ROW)  || (state == S_UNLATCH);
  assign o_busy       = (state != S_IDLE);
  assign ram.rd_en    = (state == S_ADDR);
  assign ram.rd_addr  = ADDR_W'(int'(buf_sel) * ROWS * COLS + int'(row) * COLS + int'(col));

  assign frame_end    = (state == S_ROW) && (row == ROW_LAST) && (pwm == PWM_LAST);
  assign o_frame_done = frame_end;
  // A request arriving in the wrap cycle itself is honoured immediately.
  assign o_swap_ack   = frame_end && (swap_pend || i_swap_req);

  assign o_data_r     = r_q;
  assign o_data_g     = g_q;
  assign o_data_b     = b_q;
  assign o_row_select = row;
  assign o_buf_sel    = buf_sel;

  // Threshold each colour component of each pixel in the returned word against pwm.
  always_comb begin
    lane_r = '0;
    lane_g = '0;
    lane_b = '0;
    pix    = '0;
    for (int unsigned p = 0; p < LANES; p++) begin
      pix       = ram.rd_data[p*PIX_W +: PIX_W];
      lane_r[p] = pix[3*PWM_BITS-1 -: PWM_BITS] > pwm;
      lane_g[p] = pix[2*PWM_BITS-1 -: PWM_BITS] > pwm;
      lane_b[p] = pix[PWM_BITS-1:0] > pwm;
    end
  end

  // Next-state and datapath update for the scan sequence.
  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    pwm_n   = pwm;
    buf_n   = buf_sel;
    pend_n  = swap_pend | i_swap_req;
    r_n     = r_q;
    g_n     = g_q;
    b_n     = b_q;
    unique case (state)
      S_IDLE:  if (i_enable) state_n = S_ADDR;
      S_ADDR:  state_n = S_DATA;
      S_DATA: begin
        r_n     = lane_r;
        g_n     = lane_g;
        b_n     = lane_b;
        state_n = S_CLK;
      end
      S_CLK: begin
        if (col == COL_LAST) begin
          col_n   = '0;
          state_n = S_BLANK;
        end else begin
          col_n   = col + 1'b1;
          state_n = S_ADDR;
        end
      end
      S_BLANK: state_n = S_LATCH;
      S_LATCH: state_n = S_ROW;
      S_ROW: begin
        state_n = S_UNLATCH;
        if (row == ROW_LAST) begin
          row_n = '0;
          if (pwm == PWM_LAST) begin
            pwm_n = '0;
            if (o_swap_ack) begin
              buf_n  = ~buf_sel;
              pend_n = 1'b0;
            end
          end else begin
            pwm_n = pwm + 1'b1;
          end
        end else begin
          row_n = row + 1'b1;
        end
      end
      S_UNLATCH: state_n = S_UNBLANK;
      S_UNBLANK: state_n = i_enable ? S_ADDR : S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      pwm       <= '0;
      buf_sel   <= 1'b0;
      swap_pend <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      row       <= row_n;
      pwm       <= pwm_n;
      buf_sel   <= buf_n;
      swap_pend <= pend_n;
      r_q       <= r_n;
      g_q       <= g_n;
      b_q       <= b_n;
    end
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Scoreboard bench for hub75_scan_driver (COLS=4, ROWS=2, CHAINS=1, PWM_BITS=2).
// Stimulus pushes expected read addresses, lane values, row advances and frame
// events; a negedge monitor pops and compares as the DUT produces them.
module tb_hub75_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       swap_req = 1'b0;
  logic       dclk, dlat, dblank, swap_ack, frame_done, busy, buf_sel;
  logic [1:0] dr, dg, db;
  logic [0:0] row_sel;

  hub75_scan_driver_if #(.ADDR_W(5), .DATA_W(12)) ram_if ();

  hub75_scan_driver #(
    .COLS(4), .ROWS(2), .CHAINS(1), .PWM_BITS(2), .ROW_W(1), .ADDR_W(5)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_swap_req(swap_req),
    .ram(ram_if),
    .o_data_clock(dclk), .o_data_latch(dlat), .o_data_blank(dblank),
    .o_data_r(dr), .o_data_g(dg), .o_data_b(db),
    .o_row_select(row_sel), .o_buf_sel(buf_sel), .o_swap_ack(swap_ack),
    .o_frame_done(frame_done), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Frame RAM model: buffer 0 at 0..7, buffer 1 at 8..15, one-cycle read latency.
  logic [11:0] mem [0:31];
  always @(posedge clk) if (ram_if.rd_en) ram_if.rd_data <= mem[ram_if.rd_addr];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr [$];
  logic [5:0]  exp_rgb  [$];
  logic        exp_row  [$];
  logic        exp_swap [$];
  logic [5:0]  exp_tab  [0:5];
  int          fd_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // One full row of shifts from buffer b, row r, PWM pass p.
  task automatic push_row(input int b, input int r, input int p);
    for (int c = 0; c < 4; c++) begin
      exp_addr.push_back(32'(b * 8 + r * 4 + c));
      exp_rgb.push_back(exp_tab[b * 3 + p]);
    end
    exp_row.push_back(r == 0);
  endtask

  // Monitor: compare every DUT output event against the head of its queue.
  int unsigned last_lr = 0, last_fd = 0;
  bit          have_lr = 0, have_fd = 0, idle_seen = 0, prev_lat = 0;
  int          lat_w = 0, nclk = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      have_lr = 0; have_fd = 0; prev_lat = 0; lat_w = 0; nclk = 0;
    end else begin
      if (!busy) idle_seen = 1;
      if (ram_if.rd_en) begin
        if (exp_addr.size() == 0) check("unexpected read", 32'(ram_if.rd_addr), 32'hFFFF);
        else check("rd_addr", 32'(ram_if.rd_addr), exp_addr.pop_front());
      end
      if (dclk) begin
        nclk++;
        if (exp_rgb.size() == 0) check("unexpected shift", 32'({dr, dg, db}), 32'hFFFF);
        else check("rgb lanes", 32'({dr, dg, db}), 32'(exp_rgb.pop_front()));
      end
      if (dlat) begin
        if (!prev_lat) begin
          check("clocks per row", 32'(nclk), 32'd4);
          nclk = 0;
          if (have_lr && !idle_seen) check("row period", cyc - last_lr, 32'd17);
          have_lr = 1; last_lr = cyc; idle_seen = 0; lat_w = 0;
        end
        lat_w++;
      end else if (prev_lat) begin
        check("latch width", 32'(lat_w), 32'd2);
        if (exp_row.size() == 0) check("unexpected row", 32'(row_sel), 32'hFFFF);
        else check("row_select", 32'(row_sel), 32'(exp_row.pop_front()));
      end
      if (frame_done) begin
        fd_seen++;
        if (have_fd) check("frame period", cyc - last_fd, 32'd102);
        have_fd = 1; last_fd = cyc;
        if (exp_swap.size() == 0) check("unexpected frame_done", 32'd1, 32'd0);
        else check("swap_ack", 32'(swap_ack), 32'(exp_swap.pop_front()));
      end else if (swap_ack) begin
        check("swap_ack without frame_done", 32'd1, 32'd0);
      end
      prev_lat = dlat;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 12'h000;
    // pixel = {R,G,B}; word = {bottom, top}
    for (int i = 0; i < 8; i++)  mem[i] = 12'b001110_111000;  // top 3,2,0  bottom 0,3,2
    for (int i = 8; i < 16; i++) mem[i] = 12'b111000_100011;  // top 2,0,3  bottom 3,2,0
    // {r[1:0], g[1:0], b[1:0]} with bit0 = top, bit1 = bottom
    exp_tab[0] = 6'b01_11_10; exp_tab[1] = 6'b01_11_10; exp_tab[2] = 6'b01_10_00;
    exp_tab[3] = 6'b11_10_01; exp_tab[4] = 6'b11_10_01; exp_tab[5] = 6'b10_00_01;

    repeat (3) @(negedge clk);
    check("reset blank", 32'(dblank), 32'd1);
    check("reset clock", 32'(dclk), 32'd0);
    check("reset latch", 32'(dlat), 32'd0);
    check("reset rd_en", 32'(ram_if.rd_en), 32'd0);
    check("reset rgb", 32'({dr, dg, db}), 32'd0);
    check("reset row", 32'(row_sel), 32'd0);
    check("reset buf_sel", 32'(buf_sel), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset pulses", 32'({swap_ack, frame_done}), 32'd0);
    rst_n = 1'b1;

    // Frame 1 from buffer 0 (swap requested mid-frame), frame 2 from buffer 1,
    // then row 0 and row 1 of frame 3 around an enable drop.
    for (int p = 0; p < 3; p++) for (int r = 0; r < 2; r++) push_row(0, r, p);
    exp_swap.push_back(1'b1);
    for (int p = 0; p < 3; p++) for (int r = 0; r < 2; r++) push_row(1, r, p);
    exp_swap.push_back(1'b0);
    push_row(1, 0, 0);
    push_row(1, 1, 0);

    @(negedge clk);
    en = 1'b1;
    repeat (40) @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    repeat (10) @(negedge clk);
    swap_req = 1'b1;   // already pending: must not cause a second swap
    @(negedge clk);
    swap_req = 1'b0;

    for (int i = 0; i < 1000 && fd_seen < 2; i++) @(negedge clk);
    check("two frames seen", 32'(fd_seen), 32'd2);
    check("buf_sel after swap", 32'(buf_sel), 32'd1);

    // Drop enable while column 1 of row 0 (buffer 1) is being fetched.
    for (int i = 0; i < 100 && !(ram_if.rd_en && ram_if.rd_addr == 5'd9); i++) @(negedge clk);
    check("reached col 1", 32'(ram_if.rd_addr), 32'd9);
    #1 en = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);
    check("idle blank", 32'(dblank), 32'd1);
    check("idle row retained", 32'(row_sel), 32'd1);
    check("row 0 completed reads", 32'(exp_addr.size()), 32'd4);
    repeat (10) @(negedge clk);
    check("no reads while idle", 32'(exp_addr.size()), 32'd4);
    en = 1'b1;

    // Resume on row 1; hit reset in the CLK state of column 2.
    for (int i = 0; i < 100 && exp_rgb.size() != 2; i++) @(posedge clk);
    check("resumed shifting", 32'(exp_rgb.size()), 32'd2);
    repeat (3) @(negedge clk);
    #1;
    check("in CLK before reset", 32'(dclk), 32'd1);
    check("pending shifts", 32'(exp_rgb.size()), 32'd1);
    check("pending reads", 32'(exp_addr.size()), 32'd1);
    check("frame events consumed", 32'(exp_swap.size()), 32'd0);
    rst_n = 1'b0;
    en = 1'b0;
    @(negedge clk);
    check("mid reset blank", 32'(dblank), 32'd1);
    check("mid reset clock", 32'(dclk), 32'd0);
    check("mid reset row", 32'(row_sel), 32'd0);
    check("mid reset buf_sel", 32'(buf_sel), 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    exp_addr.delete();
    exp_rgb.delete();
    exp_row.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("stays idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
